// File: rtl/ifid_stage_ctrl.sv
// ifid_stage_ctrl: PC, IF/ID register and ID/EX control with stall, bubble and flush handling.
// Define STALL_CNT_EN to add the saturating stall_cnt port and counter.
module ifid_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcen,
  input  logic        ctrlsig,
  input  logic        flush,
  input  logic [31:0] target,
  input  logic [31:0] imem_instr,
  input  logic [9:0]  id_ctrl,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pcplus4,
  output logic        ifid_valid,
  output logic [9:0]  idex_ctrl,
  output logic [1:0]  state
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
  state_t cur, nxt;
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc + 32'd4;
  assign state = cur;
  always_comb begin
    nxt = flush ? FLUSH : (pcen ? RUN : STALL);
  end
  always_ff @(posedge clk) begin
    if (rst) cur <= RUN;
    else cur <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ifid_instr <= '0;
      ifid_pcplus4 <= '0;
      ifid_valid <= 1'b0;
      idex_ctrl <= '0;
    end else begin
      pc <= flush ? target : (pcen ? pc_plus4 : pc);
      ifid_instr <= flush ? '0 : (pcen ? imem_instr : ifid_instr);
      ifid_pcplus4 <= flush ? '0 : (pcen ? pc_plus4 : ifid_pcplus4);
      ifid_valid <= flush ? 1'b0 : (pcen ? 1'b1 : ifid_valid);
      // bubble uses the IF/ID validity seen before this edge
      idex_ctrl <= (flush || ctrlsig || !ifid_valid) ? '0 : id_ctrl;
    end
  end
`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (!pcen && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/ifid_stage_ctrl.md
IFID_STAGE_CTRL -- requirements
Module: ifid_stage_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: pcen  in  1  1 = advance PC and IF/ID; 0 = hold both.
REQ-004 SHALL have ports: ctrlsig  in  1  1 = insert bubble (all-zero control) into ID/EX.
REQ-005 SHALL have ports: flush  in  1  taken branch/jump resolved in EX; squash IF/ID and ID/EX.
REQ-006 SHALL have ports: target  in  32  redirect PC used with flush.
REQ-007 SHALL have ports: imem_instr  in  32  instruction fetched at pc.
REQ-008 SHALL have ports: id_ctrl  in  10  decoder control bundle for the instruction in IF/ID.
REQ-009 SHALL have ports: pc  out  32  fetch address register.
REQ-010 SHALL have ports: ifid_instr  out  32  IF/ID instruction.
REQ-011 SHALL have ports: ifid_pcplus4  out  32  IF/ID PC+4.
REQ-012 SHALL have ports: ifid_valid  out  1  IF/ID holds a real instruction.
REQ-013 SHALL have ports: idex_ctrl  out  10  registered ID/EX control bundle.
REQ-014 SHALL have ports: state  out  2  RUN=00, STALL=01, FLUSH=10.
REQ-015 SHALL have ports: stall_cnt  out  16  stall-cycle count (present only under STALL_CNT_EN).

Function
REQ-016 SHALL apply priority flush > pcen at every rising edge.
REQ-017 SHALL set pc <= target on flush; pc <= pc+4 on pcen=1; hold otherwise.
REQ-018 SHALL compute pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000), no carry out.
REQ-019 SHALL on flush load ifid_instr=0x00000000, ifid_pcplus4=0, ifid_valid=0.
REQ-020 SHALL on pcen=1 without flush load ifid_instr=imem_instr, ifid_pcplus4=pc+4, ifid_valid=1.
REQ-021 SHALL hold ifid_instr, ifid_pcplus4 and ifid_valid unchanged when pcen=0 and flush=0.
REQ-022 SHALL load idex_ctrl=0 when flush=1 or ctrlsig=1 or ifid_valid=0; else idex_ctrl=id_ctrl; one-cycle latency.
REQ-023 SHALL treat ctrlsig independently of pcen: pcen=0,ctrlsig=0 holds PC/IF/ID and passes id_ctrl; pcen=1,ctrlsig=1 advances and bubbles.
REQ-024 SHALL transition state: flush -> FLUSH; else pcen=0 -> STALL; else -> RUN, from any state.
REQ-025 SHALL keep FLUSH for exactly one cycle unless flush is reasserted.
REQ-026 SHALL allow unbounded consecutive STALL cycles without losing IF/ID contents.
REQ-027 SHALL honour flush arriving during STALL: redirect PC and squash same edge, no stall residue.

Reset
REQ-028 SHALL on rst=1 at a rising edge set pc=0x00000000, ifid_instr=0, ifid_pcplus4=0, ifid_valid=0, idex_ctrl=0, state=RUN, stall_cnt=0.
REQ-029 SHALL give rst priority over flush, pcen and ctrlsig, including mid-stall and mid-flush.
REQ-030 SHALL resume fetch at 0x00000000 on the first edge after rst deasserts with pcen=1.

Configuration
REQ-031 SHALL compile stall_cnt port and counter only when macro STALL_CNT_EN is defined.
REQ-032 SHALL with STALL_CNT_EN increment stall_cnt on each edge with pcen=0 and flush=0, saturating at 0xFFFF; rst clears it.
REQ-033 SHALL without STALL_CNT_EN omit the port and counter; all other behaviour identical.

Verification
REQ-034 SHALL cover: reset then pcen=1 for 3 cycles, imem_instr=0x8C010004 -> pc=0x0C, ifid_valid=1, ifid_pcplus4=0x0C.
REQ-035 SHALL cover: load-use, pcen=0, ctrlsig=1 for 1 cycle -> pc and ifid_instr held, idex_ctrl=0, state=STALL, then RUN with id_ctrl passed.
REQ-036 SHALL cover: flush=1, target=0x00000400 during pcen=0 -> pc=0x400, ifid_instr=0, ifid_valid=0, idex_ctrl=0, state=FLUSH.
REQ-037 SHALL cover: pc forced to 0xFFFFFFFC via flush, then pcen=1 -> pc=0x00000000, ifid_pcplus4=0x00000000.
REQ-038 SHALL cover: rst=1 asserted mid-stall with flush=1 -> all outputs at reset values, state=RUN.
REQ-039 SHALL cover (STALL_CNT_EN): 70000 cycles pcen=0 -> stall_cnt=0xFFFF; then rst -> 0.
